// File: rtl/rs_latch_bank_ctrl.sv
// rs_latch_bank_ctrl
//   Arbitrates two requesters onto a bank of N clocked RS latch cells.
//   Each operation is a round-robin grant, a clean single-bit s or r pulse
//   of PULSE_CYC cycles, and one guard cycle with s=r=0. The q bit is read
//   back at the end of the guard cycle, then the requester is acked.
//   This block is the only driver of s_out/r_out, so s=r=1 never occurs.
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   req0/op0/idx0      requester 0: request, 1=set 0=clear, latch index
//   ack0               one-cycle completion strobe to requester 0
//   req1/op1/idx1/ack1 same for requester 1
//   s_out, r_out       set / reset lines to the latch bank
//   q_in               q read back from the latch bank
//   busy               high whenever the controller is not idle
//   err                readback mismatch or bad index, last completed op
module rs_latch_bank_ctrl #(
  parameter int N         = 8,
  parameter int IDXW      = 3,
  parameter int PULSE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            op0,
  input  logic [IDXW-1:0] idx0,
  output logic            ack0,
  input  logic            req1,
  input  logic            op1,
  input  logic [IDXW-1:0] idx1,
  output logic            ack1,
  output logic [N-1:0]    s_out,
  output logic [N-1:0]    r_out,
  input  logic [N-1:0]    q_in,
  output logic            busy,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, PULSE, GUARD} state_t;

  localparam logic [IDXW:0] LP_N   = (IDXW+1)'(N);
  localparam logic [N-1:0]  LP_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [3:0]    LP_CNT = 4'(PULSE_CYC - 1);

  state_t          r_state, w_state_nxt;
  logic            r_gnt, w_gnt_nxt;
  logic            r_op, w_op_nxt;
  logic            r_ok, w_ok_nxt;
  logic [IDXW-1:0] r_idx, w_idx_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic            r_last, w_last_nxt;
  logic [N-1:0]    r_s, w_s_nxt;
  logic [N-1:0]    r_r, w_r_nxt;
  logic            r_ack0, w_ack0_nxt;
  logic            r_ack1, w_ack1_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_err, w_err_nxt;

  logic            w_elig0, w_elig1, w_sel, w_sel_op, w_sel_ok, w_qbit;
  logic [IDXW-1:0] w_sel_idx;
  logic [N-1:0]    w_sel_hot;

  always_comb begin
    // A requester whose ack is high this cycle is still lowering req;
    // masking it here prevents a second grant of the same request.
    w_elig0   = req0 & ~r_ack0;
    w_elig1   = req1 & ~r_ack1;
    w_sel     = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
    w_sel_op  = w_sel ? op1 : op0;
    w_sel_idx = w_sel ? idx1 : idx0;
    w_sel_ok  = ({1'b0, w_sel_idx} < LP_N);
    w_sel_hot = w_sel_ok ? (LP_ONE << w_sel_idx) : '0;
    w_qbit    = r_ok ? q_in[r_idx] : 1'b0;

    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_op_nxt    = r_op;
    w_ok_nxt    = r_ok;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_s_nxt     = '0;
    w_r_nxt     = '0;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_err_nxt   = r_err;

    unique case (r_state)
      IDLE: begin
        if (w_elig0 | w_elig1) begin
          w_state_nxt = PULSE;
          w_gnt_nxt   = w_sel;
          w_op_nxt    = w_sel_op;
          w_ok_nxt    = w_sel_ok;
          w_idx_nxt   = w_sel_idx;
          w_cnt_nxt   = LP_CNT;
          w_last_nxt  = w_sel;
          w_s_nxt     = w_sel_op ? w_sel_hot : '0;
          w_r_nxt     = w_sel_op ? '0 : w_sel_hot;
        end
      end
      PULSE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = GUARD;
        end else begin
          // Outputs are registered, so holding the current pulse is
          // simply re-loading it until the count expires.
          w_cnt_nxt = r_cnt - 4'd1;
          w_s_nxt   = r_s;
          w_r_nxt   = r_r;
        end
      end
      GUARD: begin
        w_state_nxt = IDLE;
        w_err_nxt   = ~r_ok | (w_qbit != r_op);
        w_ack0_nxt  = ~r_gnt;
        w_ack1_nxt  = r_gnt;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_op    <= 1'b0;
      r_ok    <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_s     <= '0;
      r_r     <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_op    <= w_op_nxt;
      r_ok    <= w_ok_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_s     <= w_s_nxt;
      r_r     <= w_r_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign s_out = r_s;
  assign r_out = r_r;
  assign ack0  = r_ack0;
  assign ack1  = r_ack1;
  assign busy  = r_busy;
  assign err   = r_err;

endmodule

// File: tb/tb_rs_latch_bank_ctrl.sv
module tb_rs_latch_bank_ctrl;
  localparam int N    = 8;
  localparam int P    = 2;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
  logic [2:0] idx0 = '0, idx1 = '0;
  logic       ack0, ack1, busy, err;
  logic [7:0] s_out, r_out, q_in;
  logic [7:0] q_bank = '0;
  logic [7:0] fault = '0;

  rs_latch_bank_ctrl #(.N(8), .IDXW(3), .PULSE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .idx0(idx0), .ack0(ack0),
    .req1(req1), .op1(op1), .idx1(idx1), .ack1(ack1),
    .s_out(s_out), .r_out(r_out), .q_in(q_in), .busy(busy), .err(err)
  );

  // Behavioural latch bank; faulted bits read back as 0.
  always @(posedge clk) q_bank <= (q_bank | s_out) & ~r_out;
  assign q_in = q_bank & ~fault;

  logic       b_req0 = 1'b0, b_op0 = 1'b0;
  logic [2:0] b_idx0 = '0;
  logic       b_ack0, b_ack1, b_busy, b_err;
  logic [5:0] b_s, b_r;
  logic [5:0] b_q = '0;

  rs_latch_bank_ctrl #(.N(6), .IDXW(3), .PULSE_CYC(2)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .op0(b_op0), .idx0(b_idx0), .ack0(b_ack0),
    .req1(1'b0), .op1(1'b0), .idx1(3'd0), .ack1(b_ack1),
    .s_out(b_s), .r_out(b_r), .q_in(b_q), .busy(b_busy), .err(b_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inv();
    chk("s_and_r", 32'(s_out & r_out), 32'd0);
    chk("one_line", 32'($countones(s_out | r_out) <= 1), 32'd1);
    chk("one_ack", 32'(ack0 & ack1), 32'd0);
  endtask

  // Cycle table: outputs expected in that cycle, then inputs driven for it.
  typedef struct {
    bit [7:0] es, er;
    bit       ea0, ea1, eb, ee;
    bit       rq0, o0;
    bit [2:0] i0;
    bit       rq1, o1;
    bit [2:0] i1;
    bit [7:0] flt;
  } vec_t;
  vec_t tbl[22];

  // Transaction-level reference: per-cycle expected outputs scheduled at grant.
  typedef struct { bit op; bit [2:0] idx; } op_t;
  op_t      q0[$], q1[$];
  bit [7:0] m_s[MAXC], m_r[MAXC];
  bit       m_a0[MAXC], m_a1[MAXC], m_busy[MAXC], m_ev[MAXC], m_eval[MAXC];
  int       t, free_at;
  bit       m_last, cur_err;

  task automatic model_clear();
    for (int i = 0; i < MAXC; i++) begin
      m_s[i] = '0; m_r[i] = '0; m_a0[i] = 0; m_a1[i] = 0;
      m_busy[i] = 0; m_ev[i] = 0; m_eval[i] = 0;
    end
    t = 0; free_at = 0; m_last = 1; cur_err = 0;
    q0.delete(); q1.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; req0 = 0; req1 = 0; op0 = 0; op1 = 0; idx0 = '0; idx1 = '0; fault = '0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic step(input bit rnd);
    bit       e0, e1, g, o;
    bit [2:0] i;
    bit [7:0] pv;
    @(negedge clk);
    if (m_ev[t]) cur_err = m_eval[t];
    chk("m_s", 32'(s_out), 32'(m_s[t]));
    chk("m_r", 32'(r_out), 32'(m_r[t]));
    chk("m_ack0", 32'(ack0), 32'(m_a0[t]));
    chk("m_ack1", 32'(ack1), 32'(m_a1[t]));
    chk("m_busy", 32'(busy), 32'(m_busy[t]));
    chk("m_err", 32'(err), 32'(cur_err));
    chk_inv();
    if (m_a0[t] && q0.size() > 0) void'(q0.pop_front());
    if (m_a1[t] && q1.size() > 0) void'(q1.pop_front());
    if (rnd) begin
      if (q0.size() < 3 && $urandom_range(0, 3) == 0)
        q0.push_back('{op: 1'($urandom_range(0, 1)), idx: 3'($urandom_range(0, 7))});
      if (q1.size() < 3 && $urandom_range(0, 3) == 0)
        q1.push_back('{op: 1'($urandom_range(0, 1)), idx: 3'($urandom_range(0, 7))});
    end
    req0 = (q0.size() > 0);
    if (req0) begin op0 = q0[0].op; idx0 = q0[0].idx; end
    req1 = (q1.size() > 0);
    if (req1) begin op1 = q1[0].op; idx1 = q1[0].idx; end
    if (t >= free_at) begin
      e0 = req0 && !m_a0[t];
      e1 = req1 && !m_a1[t];
      if (e0 || e1) begin
        g = (e0 && e1) ? !m_last : e1;
        m_last = g;
        o = g ? op1 : op0;
        i = g ? idx1 : idx0;
        pv = (int'(i) < N) ? (8'd1 << i) : 8'd0;
        for (int c = 1; c <= P; c++) begin
          m_s[t+c] = o ? pv : 8'd0;
          m_r[t+c] = o ? 8'd0 : pv;
          m_busy[t+c] = 1;
        end
        m_busy[t+P+1] = 1;
        if (g) m_a1[t+P+2] = 1; else m_a0[t+P+2] = 1;
        m_ev[t+P+2] = 1;
        m_eval[t+P+2] = (int'(i) >= N) || (o && fault[i]);
        free_at = t + P + 2;
      end
    end
    t++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    tbl[0]  = '{8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 3'd5, 1, 1, 3'd2, 8'h00};
    tbl[1]  = '{8'h00, 8'h20, 0, 0, 1, 0, 1, 0, 3'd5, 1, 1, 3'd2, 8'h00};
    tbl[2]  = '{8'h00, 8'h20, 0, 0, 1, 0, 1, 0, 3'd5, 1, 1, 3'd2, 8'h00};
    tbl[3]  = '{8'h00, 8'h00, 0, 0, 1, 0, 1, 0, 3'd5, 1, 1, 3'd2, 8'h00};
    tbl[4]  = '{8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 3'd5, 1, 1, 3'd2, 8'h00};
    tbl[5]  = '{8'h04, 8'h00, 0, 0, 1, 0, 0, 0, 3'd5, 1, 1, 3'd2, 8'h00};
    tbl[6]  = '{8'h04, 8'h00, 0, 0, 1, 0, 0, 0, 3'd5, 1, 1, 3'd2, 8'h00};
    tbl[7]  = '{8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 3'd5, 1, 1, 3'd2, 8'h00};
    tbl[8]  = '{8'h00, 8'h00, 0, 1, 0, 0, 1, 1, 3'd3, 0, 1, 3'd2, 8'h00};
    tbl[9]  = '{8'h08, 8'h00, 0, 0, 1, 0, 1, 1, 3'd3, 0, 0, 3'd0, 8'h00};
    tbl[10] = '{8'h08, 8'h00, 0, 0, 1, 0, 1, 1, 3'd3, 0, 0, 3'd0, 8'h00};
    tbl[11] = '{8'h00, 8'h00, 0, 0, 1, 0, 1, 1, 3'd3, 0, 0, 3'd0, 8'h00};
    tbl[12] = '{8'h00, 8'h00, 1, 0, 0, 0, 0, 1, 3'd3, 1, 1, 3'd7, 8'h80};
    tbl[13] = '{8'h80, 8'h00, 0, 0, 1, 0, 0, 1, 3'd3, 1, 1, 3'd7, 8'h80};
    tbl[14] = '{8'h80, 8'h00, 0, 0, 1, 0, 0, 1, 3'd3, 1, 1, 3'd7, 8'h80};
    tbl[15] = '{8'h00, 8'h00, 0, 0, 1, 0, 0, 1, 3'd3, 1, 1, 3'd7, 8'h80};
    tbl[16] = '{8'h00, 8'h00, 0, 1, 0, 1, 1, 0, 3'd3, 0, 1, 3'd7, 8'h80};
    tbl[17] = '{8'h00, 8'h08, 0, 0, 1, 1, 1, 0, 3'd3, 0, 1, 3'd7, 8'h80};
    tbl[18] = '{8'h00, 8'h08, 0, 0, 1, 1, 1, 0, 3'd3, 0, 1, 3'd7, 8'h80};
    tbl[19] = '{8'h00, 8'h00, 0, 0, 1, 1, 1, 0, 3'd3, 0, 1, 3'd7, 8'h80};
    tbl[20] = '{8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 3'd3, 0, 0, 3'd0, 8'h80};
    tbl[21] = '{8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 3'd0, 8'h00};

    // Reset held with a request pending: everything must stay quiet.
    rst_n = 0; req0 = 1; op0 = 1; idx0 = 3'd3;
    @(negedge clk);
    @(negedge clk);
    chk("rst_s", 32'(s_out), 32'd0);
    chk("rst_r", 32'(r_out), 32'd0);
    chk("rst_ack", 32'({ack0, ack1}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst6", 32'({b_s, b_r, b_ack0, b_busy, b_err}), 32'd0);
    req0 = 0;
    rst_n = 1;

    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_s", k), 32'(s_out), 32'(tbl[k].es));
      chk($sformatf("tbl%0d_r", k), 32'(r_out), 32'(tbl[k].er));
      chk($sformatf("tbl%0d_ack0", k), 32'(ack0), 32'(tbl[k].ea0));
      chk($sformatf("tbl%0d_ack1", k), 32'(ack1), 32'(tbl[k].ea1));
      chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].eb));
      chk($sformatf("tbl%0d_err", k), 32'(err), 32'(tbl[k].ee));
      chk_inv();
      req0 = tbl[k].rq0; op0 = tbl[k].o0; idx0 = tbl[k].i0;
      req1 = tbl[k].rq1; op1 = tbl[k].o1; idx1 = tbl[k].i1;
      fault = tbl[k].flt;
    end

    // Out-of-range index on a 6-cell bank: no line activity, ack, err.
    @(negedge clk);
    b_req0 = 1; b_op0 = 1; b_idx0 = 3'd6;
    for (int c = 1; c <= P + 1; c++) begin
      @(negedge clk);
      chk("n6_s", 32'(b_s), 32'd0);
      chk("n6_r", 32'(b_r), 32'd0);
      chk("n6_busy", 32'(b_busy), 32'd1);
      chk("n6_ack_early", 32'(b_ack0), 32'd0);
    end
    @(negedge clk);
    chk("n6_ack", 32'(b_ack0), 32'd1);
    chk("n6_err", 32'(b_err), 32'd1);
    chk("n6_busy_end", 32'(b_busy), 32'd0);
    b_req0 = 0;

    // Reset in the middle of a pulse: lines drop at once, no ack, re-grant.
    do_reset();
    req0 = 1; op0 = 1; idx0 = 3'd4;
    @(negedge clk);
    chk("mid_s_pre", 32'(s_out), 32'h10);
    #2 rst_n = 0;
    #1;
    chk("mid_s", 32'(s_out), 32'd0);
    chk("mid_r", 32'(r_out), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ack", 32'({ack0, ack1}), 32'd0);
    @(negedge clk);
    chk("mid_ack_hold", 32'({ack0, ack1}), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("regrant_s", 32'(s_out), 32'h10);
    found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (ack0) found = 1;
    end
    chk("regrant_ack", 32'(found), 32'd1);
    chk("regrant_err", 32'(err), 32'd0);
    req0 = 0;

    // Requester 1 keeps req high for three ops, requester 0 asks once.
    do_reset();
    model_clear();
    q1.push_back('{op: 1, idx: 3'd1});
    q1.push_back('{op: 0, idx: 3'd1});
    q1.push_back('{op: 1, idx: 3'd6});
    q0.push_back('{op: 1, idx: 3'd0});
    for (int c = 0; c < 24; c++) step(0);
    chk("alt_drained", 32'(q0.size() + q1.size()), 32'd0);

    // Random traffic with two faulted readback bits.
    do_reset();
    model_clear();
    fault = 8'h81;
    for (int c = 0; c < 600; c++) step(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs_latch_bank_ctrl.md
Name: rs_latch_bank_ctrl

Overview:
- Sequencing and arbitration controller for a bank of N clocked RS latch cells, each with inputs s/r and outputs q/qn.
- Two requesters share the bank. Each asks to set or clear one latch by index.
- The block grants round-robin, drives a clean single-bit s or r pulse, then inserts a guard cycle with s=r=0.
- It reads back q to confirm the write and acks the requester. It is the only driver of the bank's s/r lines, and it guarantees the forbidden s=r=1 condition never occurs.

Parameters:
- N, 8, number of latch cells in the bank (2..32).
- IDXW, 3, width of the index fields; must satisfy 2^IDXW >= N.
- PULSE_CYC, 2, number of clock cycles the s or r pulse is held (1..15).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 request; held high until ack0.
- op0  in  1  requester 0 operation: 1=set, 0=clear; stable while req0 is high.
- idx0  in  IDXW  requester 0 latch index; stable while req0 is high.
- ack0  out  1  one-cycle completion strobe to requester 0.
- req1, op1, idx1, ack1  same as the requester 0 signals, for requester 1.
- s_out  out  N  set lines to the latch bank.
- r_out  out  N  reset lines to the latch bank.
- q_in  in  N  q outputs read back from the latch bank.
- busy  out  1  high whenever state != IDLE.
- err  out  1  readback-mismatch / bad-index flag from the last completed operation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; s_out=0, r_out=0, ack0=ack1=0, busy=0, err=0; last-served pointer=1, so requester 0 wins the first contention. Reset applied mid-pulse drops s_out/r_out to 0 immediately, with no ack.
- All outputs are registered.
- States are IDLE, PULSE, GUARD.
- IDLE: eligible(i) = req_i & ~ack_i. A requester whose ack is high this cycle is not eligible, which blocks double-grant while it drops req.
  - If exactly one requester is eligible, grant it.
  - If both are eligible, grant the one != last-served.
  - On grant: latch gnt, op, idx; load the counter with PULSE_CYC-1; go to PULSE; update last-served=gnt.
- PULSE: if idx<N, s_out=op?onehot(idx):0 and r_out=op?0:onehot(idx); if idx>=N, both are 0. The counter decrements each cycle; at 0 go to GUARD.
- GUARD (1 cycle): s_out=r_out=0. Sample q_in[idx] at the closing edge. err <= (idx>=N) | (q_in[idx]!=op). Pulse ack_gnt=1 for one cycle. Go to IDLE.
- Latency: grant at edge k. s/r is high for cycles k+1..k+PULSE_CYC. GUARD occupies cycle k+PULSE_CYC+1. ack and err update are visible in cycle k+PULSE_CYC+2, when busy=0.
- Back-to-back: a waiting requester can be granted in the same cycle the other's ack is high. Minimum period per operation is PULSE_CYC+2 cycles.
- Invariants:
  - (s_out & r_out)==0 always.
  - popcount(s_out|r_out)<=1.
  - Never more than one ack high.
  - s/r is 0 in IDLE and GUARD.
- err holds its value until the next GUARD completes. It is not sticky across operations.
- Changes to req/op/idx after grant do not affect the operation in flight.

Test Plan:
- Reset with req0=1 → all outputs 0. Release reset; req0=1, op0=1, idx0=3 → s_out=8'h08 for exactly 2 cycles, r_out=0, then 1 guard cycle with s/r=0. Bank returns q[3]=1 → ack0 pulses once, err=0.
- Simultaneous req0 (clear idx 5) and req1 (set idx 2) from reset → requester 0 served first (r_out=8'h20), then requester 1 immediately after (s_out=8'h04). Each ack fires once; total 8 cycles.
- Requester 1 holds req continuously for 3 ops while requester 0 requests once → strict alternation when both are pending. No op is granted on a cycle when that requester's own ack is high.
- Readback fault: set idx 7 with q_in forced to 0 → ack fires and err=1. Next good op clears err to 0.
- N=6 instance, idx=6 → no s/r activity for the full op, ack still fires, err=1.
- rst_n pulsed low mid-PULSE → s_out/r_out drop to 0 asynchronously. No ack is issued. After release the controller is IDLE and re-grants the still-pending request.
